// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package serial_add_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } sa_state_t;

    // Step-counter width: one bit even when a single nibble makes up the word.
    function automatic int idx_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/nibble_adder4.sv
// Combinational 4-bit ripple adder; the only arithmetic the sequencer time-shares.
module nibble_adder4
    import serial_add_pkg::*;
(
    input  logic [NIB_W-1:0] A,
    input  logic [NIB_W-1:0] B,
    input  logic             Cin,
    output logic [NIB_W-1:0] S,
    output logic             Cout
);

    logic c;

    always_comb begin
        S = '0;
        c = Cin;
        for (int i = 0; i < NIB_W; i++) begin
            S[i] = A[i] ^ B[i] ^ c;
            c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
        end
        Cout = c;
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// WIDTH-bit adder built from one 4-bit adder stepped LSB nibble first.
// WIDTH must be a non-zero multiple of 4; DBG_STATE mirrors the FSM state.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             OVF,
    output logic [1:0]       DBG_STATE
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    sa_state_t        state_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [NIB_W-1:0] nib_a;
    logic [NIB_W-1:0] nib_b;
    logic [NIB_W-1:0] sum_d;
    logic             cout_d;
    logic             last;
    logic             accept;

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int n = 0; n < NIB; n++) begin
            if (idx_q == IDX_W'(n)) begin
                nib_a = a_q[n*NIB_W +: NIB_W];
                nib_b = b_q[n*NIB_W +: NIB_W];
            end
        end
    end

    nibble_adder4 u_adder (
        .A    (nib_a),
        .B    (nib_b),
        .Cin  (carry_q),
        .S    (sum_d),
        .Cout (cout_d)
    );

    // Handshake: START is taken at a rising edge only in IDLE or FIN (ignored in RUN);
    // DONE is a one-cycle pulse with S/COUT/OVF valid, held until the next accept.
    assign last   = (idx_q == IDX_LAST);
    assign accept = START && ((state_q == IDLE) || (state_q == FIN));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                end
                RUN: begin
                    for (int n = 0; n < NIB; n++) begin
                        if (idx_q == IDX_W'(n)) begin
                            s_q[n*NIB_W +: NIB_W] <= sum_d;
                        end
                    end
                    carry_q <= cout_d;
                    if (last) begin
                        // idx holds at the last step so it never wraps inside RUN
                        cout_q  <= cout_d;
                        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (sum_d[NIB_W-1] != a_q[WIDTH-1]);
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            if (accept) begin
                a_q     <= A;
                b_q     <= B;
                carry_q <= CIN;
                idx_q   <= '0;
                state_q <= RUN;
                busy_q  <= 1'b1;
            end
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign S         = s_q;
    assign COUT      = cout_q;
    assign OVF       = ovf_q;
    assign DBG_STATE = state_q;

endmodule
